// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sync_debounce
//  Purpose  : Multi-channel input conditioner. Every asynchronous input
//             (photodiode comparator, buttons, mode switches) is brought into
//             the clk domain through a STAGES-deep flop chain. A per-channel
//             stability filter then removes glitches and contact bounce.
//             The block reports the raw synchronised level, the debounced
//             level, and one-cycle edge pulses.
//
//  Ports    : clk      in   1      system clock
//             reset    in   1      synchronous reset, active low
//             async    in   WIDTH  asynchronous raw inputs
//             bypass   in   1      1 = clean copies synced with one edge lag
//             synced   out  WIDTH  last flop of each synchroniser chain
//             clean    out  WIDTH  debounced level
//             rise     out  WIDTH  one-cycle pulse when clean goes 0->1
//             fall     out  WIDTH  one-cycle pulse when clean goes 1->0
//             changed  out  1      OR of all rise and fall bits
//
//  Revision : 1.0  initial release
// ============================================================================
module sync_debounce #(
    parameter int WIDTH    = 4,
    parameter int STAGES   = 2,
    parameter int DEBOUNCE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async,
    input  logic             bypass,
    output logic [WIDTH-1:0] synced,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // ------------------------------------------------------------------------
    // Parameter legality. Illegal values stop elaboration.
    // ------------------------------------------------------------------------
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_debounce: WIDTH must be >= 1");
        end
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_debounce: STAGES must be >= 2");
        end
        if (DEBOUNCE < 1) begin : g_bad_debounce
            $error("sync_debounce: DEBOUNCE must be >= 1");
        end
    endgenerate

    // The guard keeps the width expressions legal long enough for the
    // elaboration errors above to be the ones that are reported.
    localparam int CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

    // Terminal count: a mismatch seen while the counter holds this value is
    // the DEBOUNCE-th consecutive one, so clean takes the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE < 1) ? 0 : DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Synchroniser: STAGES plain flops per channel with nothing in between,
    // so the metastability settling time of each stage is not eroded.
    // Index 0 samples the pins; index STAGES-1 is the synced output.
    // ------------------------------------------------------------------------
    logic [STAGES-1:0][WIDTH-1:0] sync_stage;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_stage <= '0;
        end else begin
            sync_stage <= {sync_stage[STAGES-2:0], async};
        end
    end

    assign synced = sync_stage[STAGES-1];

    // ------------------------------------------------------------------------
    // Stability filter, one independent counter per channel. Each channel
    // computes the value clean will take on the coming edge; the edge pulses
    // are derived from that next value so they line up with the clean update.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] clean_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_next;
            logic             level_next;

            always_comb begin
                level_next = clean[i];
                cnt_next   = '0;
                if (bypass) begin
                    // Bypass discards any pending count, so re-enabling the
                    // filter always starts a fresh qualification.
                    level_next = synced[i];
                end else if (synced[i] != clean[i]) begin
                    if (cnt == CNT_LAST) begin
                        level_next = synced[i];
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                // A matching sample leaves cnt_next at zero, which is what
                // makes any glitch shorter than DEBOUNCE edges vanish.
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_next;
                end
            end

            assign clean_next[i] = level_next;
            assign rise_next[i]  = level_next & ~clean[i];
            assign fall_next[i]  = ~level_next & clean[i];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output registers. Pulses are registered alongside clean so downstream
    // logic sees the new level and its edge flag in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            clean   <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            clean   <= clean_next;
            rise    <= rise_next;
            fall    <= fall_next;
            changed <= |(rise_next | fall_next);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_debounce
//  Purpose  : Directed self-checking bench for sync_debounce with WIDTH=4,
//             STAGES=2, DEBOUNCE=4 and a 10 ns clock. Expected values are
//             hand-derived edge by edge from the behavioural description.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_debounce;

    localparam int WIDTH    = 4;
    localparam int STAGES   = 2;
    localparam int DEBOUNCE = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] async;
    logic             bypass;
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    int checks   = 0;
    int failures = 0;

    sync_debounce #(
        .WIDTH    (WIDTH),
        .STAGES   (STAGES),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .async   (async),
        .bypass  (bypass),
        .synced  (synced),
        .clean   (clean),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    // Advance one active edge, then settle 1 ns so outputs are sampled and
    // inputs are driven well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_syn, input logic [3:0] e_cln,
                           input logic [3:0] e_rise, input logic [3:0] e_fall, input logic e_chg);
        chk({tag, ".synced"}, synced, e_syn);
        chk({tag, ".clean"}, clean, e_cln);
        chk({tag, ".rise"}, rise, e_rise);
        chk({tag, ".fall"}, fall, e_fall);
        chk({tag, ".changed"}, {3'b000, changed}, {3'b000, e_chg});
    endtask

    initial begin
        reset  = 1'b0;
        bypass = 1'b0;
        async  = 4'hF;

        // ---- 1. Reset held for three edges, then release -------------------
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        end
        reset = 1'b1;
        tick();
        chk_all("rel_e1", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        tick();
        chk_all("rel_e2", 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk_all("rel_wait", 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        end
        tick();
        chk_all("rel_e6", 4'hF, 4'hF, 4'hF, 4'h0, 1'b1);
        tick();
        chk_all("rel_e7", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);

        // Bring every channel back to 0 through the filter.
        async = 4'h0;
        repeat (5) tick();
        chk("all_low_e5.clean", clean, 4'hF);
        tick();
        chk_all("all_low_e6", 4'h0, 4'h0, 4'h0, 4'hF, 1'b1);
        tick();
        chk_all("all_low_e7", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        // ---- 2. Clean step on channel 0 ------------------------------------
        async = 4'b0001;
        tick();
        chk("step_e1.synced", synced, 4'b0000);
        tick();
        chk("step_e2.synced", synced, 4'b0001);
        repeat (3) tick();
        chk_all("step_e5", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        chk_all("step_e6", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        tick();
        chk_all("step_e7", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        async = 4'b0000;
        repeat (5) tick();
        chk_all("fall_e5", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        tick();
        chk_all("fall_e6", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        tick();
        chk_all("fall_e7", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // ---- 3. Three-cycle glitch on channel 1 is rejected ----------------
        async = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) async = 4'b0000;
            tick();
            chk_all("glitch", (k >= 2 && k <= 4) ? 4'b0010 : 4'b0000,
                    4'b0000, 4'b0000, 4'b0000, 1'b0);
        end

        // ---- 4. Bounce on channel 2, then settle high ----------------------
        // Two-cycle runs never qualify; the final level settles on synced at
        // edge 14 and must surface on clean at edge 18.
        for (int k = 1; k <= 24; k++) begin
            if (k <= 12) async[2] = ((((k - 1) / 2) % 2) == 0);
            else         async[2] = 1'b1;
            tick();
            chk("bounce.rise", rise, (k == 18) ? 4'b0100 : 4'b0000);
            chk("bounce.fall", fall, 4'b0000);
            chk("bounce.clean", clean, (k >= 18) ? 4'b0100 : 4'b0000);
        end

        // ---- 5. Bypass: channel 3 follows synced with one edge lag ---------
        bypass   = 1'b1;
        async[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) async[3] = 1'b0;
            tick();
            chk_all("bypass",
                    (k >= 2 && k <= 4) ? 4'b1100 : 4'b0100,
                    (k >= 3 && k <= 5) ? 4'b1100 : 4'b0100,
                    (k == 3) ? 4'b1000 : 4'b0000,
                    (k == 6) ? 4'b1000 : 4'b0000,
                    (k == 3 || k == 6));
        end

        // Bypass asserted while channel 0 is at cnt=2.
        bypass   = 1'b0;
        async[0] = 1'b1;
        repeat (4) tick();
        chk_all("byp_pend", 4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        bypass = 1'b1;
        tick();
        chk_all("byp_take", 4'b0101, 4'b0101, 4'b0001, 4'b0000, 1'b1);
        bypass = 1'b0;
        tick();
        chk_all("byp_after", 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);

        // ---- 6. Reset while channel 0 is pending ---------------------------
        async[0] = 1'b0;
        repeat (6) tick();
        chk_all("pre_rst_fall", 4'b0100, 4'b0100, 4'b0000, 4'b0001, 1'b1);
        async[0] = 1'b1;
        repeat (4) tick();
        chk_all("pre_rst_pend", 4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        tick();
        chk_all("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_all("requal", (k >= 2) ? 4'b0101 : 4'b0000, 4'h0, 4'h0, 4'h0, 1'b0);
        end
        tick();
        chk_all("requal_e6", 4'b0101, 4'b0101, 4'b0101, 4'b0000, 1'b1);
        tick();
        chk_all("requal_e7", 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
